// File: rtl/alu_ctrl_seq_if.sv
// ALU control / multiply-divide bus between the pipeline and alu_ctrl_seq.
//
// Handshake: valid_i qualifies funct7/funct3/aluop/opa/opb for one cycle.
// There is no ready signal; the unit answers a start with stall held high
// from the start cycle until mdu_done, and mdu_done is a single-cycle pulse
// during which mdu_result is first valid (it then holds until the next start).
// valid_i seen while stall or mdu_done is high is ignored.
interface alu_ctrl_seq_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [1:0]      aluop;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      alucontrol;
    logic            stall;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    // Pipeline side: issues decode fields and operands.
    modport master (
        output valid_i, funct7, funct3, aluop, opa, opb,
        input  alucontrol, stall, mdu_done, mdu_result
    );

    // Unit side: decodes and runs the iterative multiply/divide.
    modport slave (
        input  valid_i, funct7, funct3, aluop, opa, opb,
        output alucontrol, stall, mdu_done, mdu_result
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder plus an iterative RV32M-style multiply/divide unit.
// alucontrol is purely combinational from aluop/funct7/funct3. M-ops start a
// three-state sequencer (IDLE -> BUSY for XLEN cycles -> DONE).
// Optional feature macro: ALU_CTRL_SEQ_DIV_EN enables DIV/DIVU/REM/REMU;
// without it those encodings decode as illegal (1111) and never start.
module alu_ctrl_seq #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_seq_if.slave bus,
    output logic [1:0]    o_dbg_state
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operand A is treated as signed for MULH, MULHSU, DIV, REM.
    function automatic logic f_a_signed(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    // Operand B is treated as signed for MULH, DIV, REM.
    function automatic logic f_b_signed(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_funct3;
    logic              r_a_neg;
    logic              r_b_neg;
    logic [XLEN-1:0]   r_b_mag;
    logic [2*XLEN-1:0] r_p;
    logic              r_stall;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_mop_f3_ok;
    logic              w_mop;
    logic              w_start;
    logic [3:0]        w_alucontrol;
    logic              w_in_a_neg;
    logic              w_in_b_neg;
    logic [XLEN-1:0]   w_in_a_mag;
    logic [XLEN-1:0]   w_in_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_p_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_final;

`ifdef ALU_CTRL_SEQ_DIV_EN
    assign w_mop_f3_ok = 1'b1;
`else
    assign w_mop_f3_ok = ~bus.funct3[2];
`endif

    assign w_mop   = (bus.aluop == 2'b10) && (bus.funct7 == 7'b0000001) && w_mop_f3_ok;
    // Reset beats a concurrent start: no stall, no operation.
    assign w_start = (r_state == S_IDLE) && bus.valid_i && w_mop && !reset;

    // Main ALU control decode; anything not listed is 1111.
    always_comb begin
        w_alucontrol = 4'b1111;
        case (bus.aluop)
            2'b00: w_alucontrol = 4'b0010;
            2'b01: begin
                if (bus.funct3 == 3'b000)      w_alucontrol = 4'b0110;
                else if (bus.funct3 == 3'b001) w_alucontrol = 4'b0111;
            end
            2'b10: begin
                if (bus.funct7 == 7'b0000000) begin
                    case (bus.funct3)
                        3'b000:  w_alucontrol = 4'b0010;
                        3'b001:  w_alucontrol = 4'b0100;
                        3'b010:  w_alucontrol = 4'b1001;
                        3'b011:  w_alucontrol = 4'b1010;
                        3'b100:  w_alucontrol = 4'b0011;
                        3'b101:  w_alucontrol = 4'b0101;
                        3'b110:  w_alucontrol = 4'b0001;
                        default: w_alucontrol = 4'b0000;
                    endcase
                end else if (bus.funct7 == 7'b0100000) begin
                    if (bus.funct3 == 3'b000)      w_alucontrol = 4'b0110;
                    else if (bus.funct3 == 3'b101) w_alucontrol = 4'b1011;
                end else if (w_mop) begin
                    w_alucontrol = 4'b1000;
                end
            end
            default: begin
                case (bus.funct3)
                    3'b000:  w_alucontrol = 4'b0010;
                    3'b111:  w_alucontrol = 4'b0000;
                    3'b110:  w_alucontrol = 4'b0001;
                    3'b100:  w_alucontrol = 4'b0011;
                    default: w_alucontrol = 4'b1111;
                endcase
            end
        endcase
    end

    // Both engines work on magnitudes; signs are reapplied at the end.
    assign w_in_a_neg = f_a_signed(bus.funct3) & bus.opa[XLEN-1];
    assign w_in_b_neg = f_b_signed(bus.funct3) & bus.opb[XLEN-1];
    assign w_in_a_mag = w_in_a_neg ? -bus.opa : bus.opa;
    assign w_in_b_mag = w_in_b_neg ? -bus.opb : bus.opb;

    // Shift-add step: r_p = {partial product high, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_p[2*XLEN-1:XLEN]} +
                        (r_p[0] ? {1'b0, r_b_mag} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_p[XLEN-1:1]};

`ifdef ALU_CTRL_SEQ_DIV_EN
    // Restoring step: r_p = {partial remainder, dividend bits / quotient bits}.
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    assign w_rem_sh   = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b_mag};
    assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_p[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_p[XLEN-2:0], 1'b1};
    assign w_p_next   = r_funct3[2] ? w_div_next : w_mul_next;
    // Divide by zero forces an all-ones quotient; the remainder naturally
    // comes back as the dividend. -2^(XLEN-1)/-1 wraps to the dividend.
    assign w_quo_fix  = (r_b_mag == '0) ? {XLEN{1'b1}} :
                        ((r_a_neg ^ r_b_neg) ? -w_p_next[XLEN-1:0] : w_p_next[XLEN-1:0]);
    assign w_rem_fix  = r_a_neg ? -w_p_next[2*XLEN-1:XLEN] : w_p_next[2*XLEN-1:XLEN];
`else
    assign w_p_next   = w_mul_next;
`endif

    assign w_prod_fix = (r_a_neg ^ r_b_neg) ? -w_p_next : w_p_next;

    // Result selection from the final iteration, sign-corrected.
    always_comb begin
        w_final = w_prod_fix[XLEN-1:0];
        case (r_funct3)
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_SEQ_DIV_EN
            3'b100, 3'b101:         w_final = w_quo_fix;
            3'b110, 3'b111:         w_final = w_rem_fix;
`endif
            default:                w_final = w_prod_fix[XLEN-1:0];
        endcase
    end

    // Sequencer: latch on start, iterate XLEN times, pulse done, return idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_funct3 <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_mag  <= '0;
            r_p      <= '0;
            r_stall  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_funct3 <= bus.funct3;
                        r_a_neg  <= w_in_a_neg;
                        r_b_neg  <= w_in_b_neg;
                        r_b_mag  <= w_in_b_mag;
                        r_p      <= {{XLEN{1'b0}}, w_in_a_mag};
                        r_count  <= '0;
                        r_stall  <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(XLEN - 1)) begin
                        r_result <= w_final;
                        r_stall  <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_stall <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.alucontrol = w_alucontrol;
    assign bus.stall      = r_stall | w_start;
    assign bus.mdu_done   = r_done;
    assign bus.mdu_result = r_result;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: directed corner cases plus randomized decodes and
// M-ops, checked against a plain-arithmetic reference model. Results flow
// through an expected queue consumed by an independent monitor.
module tb_alu_ctrl_seq;
    localparam int XLEN = 32;
`ifdef ALU_CTRL_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;

    logic [XLEN-1:0] exp_q[$];
    int              exp_cyc_q[$];

    alu_ctrl_seq_if #(.XLEN(XLEN)) bus ();

    alu_ctrl_seq #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference decode table
    function automatic logic [3:0] model_alu(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [1:0] op);
        logic [3:0] r_tab [8];
        r_tab = '{4'h2, 4'h4, 4'h9, 4'hA, 4'h3, 4'h5, 4'h1, 4'h0};
        case (op)
            2'd0: return 4'h2;
            2'd1: return (f3 == 3'd0) ? 4'h6 : (f3 == 3'd1) ? 4'h7 : 4'hF;
            2'd2: begin
                if (f7 == 7'h00) return r_tab[f3];
                if (f7 == 7'h20) return (f3 == 3'd0) ? 4'h6 : (f3 == 3'd5) ? 4'hB : 4'hF;
                if (f7 == 7'h01 && (DIV_EN || f3 < 3'd4)) return 4'h8;
                return 4'hF;
            end
            default: begin
                case (f3)
                    3'd0:    return 4'h2;
                    3'd7:    return 4'h0;
                    3'd6:    return 4'h1;
                    3'd4:    return 4'h3;
                    default: return 4'hF;
                endcase
            end
        endcase
    endfunction

    function automatic bit is_mop(input logic [6:0] f7, input logic [2:0] f3, input logic [1:0] op);
        return (op == 2'd2) && (f7 == 7'h01) && (DIV_EN || f3 < 3'd4);
    endfunction

    // Reference multiply/divide using native 64-bit arithmetic
    function automatic logic [31:0] model_mdu(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa;
        int          sb;
        longint      la;
        longint      lb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        case (f3)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            3'd1: begin sp = la * lb; return sp[63:32]; end
            3'd2: begin sp = la * longint'({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Driver: one decode/operation; for M-ops follows it to completion.
    task automatic apply(input logic [6:0] f7, input logic [2:0] f3, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] exp_res;
        int          nst;
        bit          seen;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct7  = f7;
        bus.funct3  = f3;
        bus.aluop   = op;
        bus.opa     = a;
        bus.opb     = b;
        #1;
        check("alucontrol", bus.alucontrol, model_alu(f7, f3, op));
        if (is_mop(f7, f3, op)) begin
            exp_res = model_mdu(f3, a, b);
            exp_q.push_back(exp_res);
            exp_cyc_q.push_back(cyc + XLEN + 1);
            check("start_stall", bus.stall, 1);
            nst  = 1;
            seen = 0;
            for (int k = 0; k < 4 * XLEN && !seen; k++) begin
                @(negedge clk);
                if (hold) begin
                    bus.opa = $urandom;
                    bus.opb = $urandom;
                end else begin
                    bus.valid_i = 1'b0;
                end
                #1;
                if (bus.mdu_done) seen = 1;
                else if (bus.stall) nst++;
            end
            bus.valid_i = 1'b0;
            check("done_seen", seen, 1);
            check("stall_cycles", nst, XLEN + 1);
            check("done_stall_low", bus.stall, 0);
            @(negedge clk);
            #1;
            check("result_hold", bus.mdu_result, exp_res);
            check("done_pulse", bus.mdu_done, 0);
        end else begin
            check("no_stall", bus.stall, 0);
            @(negedge clk);
            #1;
            check("stays_idle", dbg_state, 0);
            check("no_stall_next", bus.stall, 0);
            bus.valid_i = 1'b0;
        end
    endtask

    // Monitor / scoreboard: every mdu_done pops one expected result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.mdu_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_done got=1 exp=0");
                end else begin
                    check("mdu_result", bus.mdu_result, exp_q.pop_front());
                    check("done_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [6:0] f7;
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.funct7  = '0;
        bus.funct3  = '0;
        bus.aluop   = '0;
        bus.opa     = '0;
        bus.opb     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", dbg_state, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_done", bus.mdu_done, 0);
        check("rst_result", bus.mdu_result, 0);
        reset = 1'b0;

        // Decode spot checks
        apply(7'h00, 3'd7, 2'd2, 0, 0, 0);
        apply(7'h20, 3'd0, 2'd2, 0, 0, 0);
        apply(7'h00, 3'd4, 2'd1, 0, 0, 0);
        apply(7'h00, 3'd3, 2'd0, 0, 0, 0);
        apply(7'h20, 3'd5, 2'd2, 0, 0, 0);
        apply(7'h00, 3'd5, 2'd3, 0, 0, 0);

        // Multiply / divide corners (divide entries decode illegal without the macro)
        apply(7'h01, 3'd0, 2'd2, 32'd7, 32'hFFFFFFFD, 0);
        apply(7'h01, 3'd3, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        apply(7'h01, 3'd1, 2'd2, 32'h80000000, 32'h80000000, 0);
        apply(7'h01, 3'd2, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        apply(7'h01, 3'd4, 2'd2, 32'hFFFFFFF9, 32'd2, 0);
        apply(7'h01, 3'd6, 2'd2, 32'hFFFFFFF9, 32'd2, 0);
        apply(7'h01, 3'd5, 2'd2, 32'd1234, 32'd0, 0);
        apply(7'h01, 3'd4, 2'd2, 32'hFFFFFFF9, 32'd0, 0);
        apply(7'h01, 3'd6, 2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        apply(7'h01, 3'd4, 2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        apply(7'h01, 3'd4, 2'd2, 32'd10, 32'd2, 0);
        apply(7'h01, 3'd0, 2'd2, 32'd3, 32'd4, 0);

        // Reset in the middle of BUSY
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct7  = 7'h01;
        bus.funct3  = 3'd0;
        bus.aluop   = 2'd2;
        bus.opa     = 32'd7;
        bus.opb     = 32'd9;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("busy_before_reset", dbg_state, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_stall", bus.stall, 0);
        check("mid_rst_done", bus.mdu_done, 0);
        check("mid_rst_result", bus.mdu_result, 0);
        apply(7'h01, 3'd0, 2'd2, 32'd5, 32'd6, 0);

        // Reset concurrent with a start
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct7  = 7'h01;
        bus.funct3  = 3'd0;
        bus.aluop   = 2'd2;
        bus.opa     = 32'd11;
        bus.opb     = 32'd13;
        reset       = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check("rst_start_state", dbg_state, 0);
        check("rst_start_stall", bus.stall, 0);
        repeat (XLEN + 4) @(negedge clk);

        // Operands churning with valid held high during BUSY
        apply(7'h01, 3'd1, 2'd2, 32'hFFFFFF85, 32'd77, 1);
        apply(7'h01, 3'd0, 2'd2, 32'd5, 32'd6, 1);

        // Randomized mix of decodes and M-ops
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            apply(f7, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2,
                  rand_opnd(), rand_opnd(), bit'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 valid_i  in  1  decode inputs and operands valid this cycle.
REQ-005 funct7  in  7  instruction funct7 field.
REQ-006 funct3  in  3  instruction funct3 field.
REQ-007 aluop  in  2  main-decoder ALU class: 00 mem, 01 branch, 10 R-type, 11 I-type.
REQ-008 opa, opb  in  XLEN  rs1/rs2 operands for multiply/divide.
REQ-009 alucontrol  out  4  ALU operation select (combinational).
REQ-010 stall  out  1  pipeline hold request while multiply/divide in flight.
REQ-011 mdu_done  out  1  one-cycle pulse: mdu_result valid.
REQ-012 mdu_result  out  XLEN  multiply/divide result, held until next start.

Function
REQ-013 aluop 00 -> 0010; aluop 01: funct3 000 -> 0110, 001 -> 0111, else 1111.
REQ-014 aluop 10, funct7 0000000: funct3 000 add 0010, 111 and 0000, 110 or 0001, 100 xor 0011, 001 sll 0100, 101 srl 0101, 010 slt 1001, 011 sltu 1010.
REQ-015 aluop 10, funct7 0100000: funct3 000 sub 0110, 101 sra 1011; other funct3 -> 1111.
REQ-016 aluop 10, funct7 0000001 (M-op): alucontrol 1000 (select mdu_result); funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-017 aluop 11: funct3 000 0010, 111 0000, 110 0001, 100 0011; any other aluop/funct combination -> 1111.
REQ-018 FSM states IDLE, BUSY, DONE; start = IDLE & valid_i & legal M-op.
REQ-019 On start: opa, opb, funct3 latched; stall asserted combinationally in the start cycle; next state BUSY.
REQ-020 BUSY lasts exactly XLEN cycles (one iteration per cycle, counter width clog2(XLEN)+1), stall high throughout; then DONE.
REQ-021 DONE: mdu_done=1, stall=0, mdu_result valid; next state IDLE; total stall = XLEN+1 cycles.
REQ-022 Start may occur in the same cycle DONE returns to IDLE only from IDLE; valid_i in BUSY/DONE ignored; operand changes after start ignored.
REQ-023 Multiply: iterative shift-add on 2*XLEN product; MUL low XLEN bits, MULH/MULHSU/MULHU high XLEN bits with signed*signed / signed*unsigned / unsigned*unsigned semantics.
REQ-024 Divide: iterative restoring on magnitudes, sign fixed in DONE; quotient rounds toward zero, remainder takes dividend sign.
REQ-025 Divide by zero: quotient all-ones, remainder = dividend, same latency.
REQ-026 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder 0, same latency.
REQ-027 Non-M legal or illegal decodes never start the FSM and never assert stall.

Reset
REQ-028 reset in any state: next cycle state IDLE, stall 0, mdu_done 0, mdu_result 0, counter 0, latched operands 0.
REQ-029 reset concurrent with start: reset wins, no operation begins.
REQ-030 alucontrol remains purely combinational from funct7/funct3/aluop, unaffected by reset.

Configuration
REQ-031 Macro ALU_CTRL_SEQ_DIV_EN: defined -> DIV/DIVU/REM/REMU decoded and executed per REQ-024..026.
REQ-032 Undefined -> funct7 0000001 with funct3[2]=1 gives alucontrol 1111, no start, no stall; divider logic absent; multiply unaffected.

Verification
REQ-033 XLEN=32, aluop 10, funct7 0, funct3 111 -> alucontrol 0000; funct7 0100000 funct3 000 -> 0110; aluop 01 funct3 100 -> 1111.
REQ-034 MUL opa=7, opb=-3 -> stall high 33 cycles, mdu_done pulses cycle 34, mdu_result 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIV opa=-7, opb=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; REM 0x80000000/-1 -> 0.
REQ-036 Assert reset at BUSY cycle 10 -> next cycle stall 0, mdu_done 0, mdu_result 0; subsequent MUL 5*6 -> 30 with full latency.
REQ-037 valid_i held high with changing operands throughout BUSY -> exactly one mdu_done, result from operands at start cycle.
REQ-038 Build without ALU_CTRL_SEQ_DIV_EN: DIV 10/2 -> alucontrol 1111, stall never asserted; MUL 3*4 -> 12.
